// File: rtl/rv32_pkg.sv
// Shared RV32 constants and the fetch-buffer entry layout used by the
// instruction prefetch unit.
package rv32_pkg;

   localparam int          XLEN         = 32;
   localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;
   localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
   localparam logic [31:0] RESET_PC     = 32'h8000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   function automatic logic [31:0] pc_next(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO with wrap-around pointers, explicit occupancy count,
// flush, and a combinational head read from registered storage.
module ifu_fifo #(
   parameter  int DEPTH = 4,
   parameter  int WIDTH = 64,
   localparam int CW    = $clog2(DEPTH + 1),
   localparam int PW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             flush,
   output logic [CW-1:0]    occ,
   output logic [WIDTH-1:0] head
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]    occ_q, occ_d;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(DEPTH - 1)) begin
         return '0;
      end else begin
         return p + PW'(1);
      end
   endfunction

   // Next-state for storage, pointers and count
   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      occ_d = occ_q;
      if (flush) begin
         wr_d  = '0;
         rd_d  = '0;
         occ_d = '0;
      end else begin
         if (push) begin
            mem_d[wr_q] = push_data;
            wr_d        = ptr_inc(wr_q);
         end else begin
            wr_d = wr_q;
         end
         if (pop) begin
            rd_d = ptr_inc(rd_q);
         end else begin
            rd_d = rd_q;
         end
         case ({push, pop})
            2'b10:   occ_d = occ_q + CW'(1);
            2'b01:   occ_d = occ_q - CW'(1);
            default: occ_d = occ_q;
         endcase
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
         occ_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         occ_q <= occ_d;
      end
   end

   assign occ  = occ_q;
   assign head = mem_q[rd_q];

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction prefetch unit: issues sequential fetches, buffers in-order
// responses, drops stale responses after a redirect and halts on ebreak.
module ifu_prefetch import rv32_pkg::*; #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = rv32_pkg::RESET_PC
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        instr_ready,
   output logic        stopped
);

   localparam int CW = $clog2(DEPTH + 1);

   logic [CW-1:0] occ_s;
   logic [CW-1:0] inflight_q, inflight_d, drop_q, drop_d;
   logic          stopped_q, stopped_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
   logic [CW:0]   budget_s;
   logic          req_valid_s, req_fire_s, push_s, pop_s;
   fetch_entry_t  push_entry_s, head_s;

   // occ + inflight bounded by DEPTH guarantees every response a slot
   assign budget_s     = {1'b0, occ_s} + {1'b0, inflight_q};
   assign req_valid_s  = rst_n && !stopped_q && !redirect_valid && (budget_s < (CW+1)'(DEPTH));
   assign req_fire_s   = req_valid_s && imem_req_ready;
   assign push_s       = imem_resp_valid && !redirect_valid && (drop_q == '0) && !stopped_q;
   assign pop_s        = instr_valid && instr_ready && !redirect_valid;
   assign push_entry_s = '{pc: resp_pc_q, instr: imem_resp_data};

   ifu_fifo #(.DEPTH(DEPTH), .WIDTH(64)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_s),
      .push_data (push_entry_s),
      .pop       (pop_s),
      .flush     (redirect_valid),
      .occ       (occ_s),
      .head      (head_s)
   );

   // Next-state for PCs, request/drop counters and the stop flag
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      drop_d     = drop_q;
      stopped_d  = stopped_q;
      inflight_d = inflight_q + CW'(req_fire_s) - CW'(imem_resp_valid);
      if (redirect_valid) begin
         fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
         resp_pc_d  = redirect_pc & 32'hFFFF_FFFC;
         drop_d     = inflight_d;
         stopped_d  = 1'b0;
      end else begin
         if (req_fire_s) begin
            fetch_pc_d = pc_next(fetch_pc_q);
         end else begin
            fetch_pc_d = fetch_pc_q;
         end
         if (imem_resp_valid && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
         end else begin
            drop_d = drop_q;
         end
         if (push_s) begin
            resp_pc_d = pc_next(resp_pc_q);
            stopped_d = (imem_resp_data == EBREAK_INSTR);
         end else begin
            resp_pc_d = resp_pc_q;
            stopped_d = stopped_q;
         end
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         inflight_q <= '0;
         drop_q     <= '0;
         stopped_q  <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
         stopped_q  <= stopped_d;
      end
   end

   assign imem_req_valid = req_valid_s;
   assign imem_req_addr  = fetch_pc_q;
   assign instr_valid    = (occ_s != '0);
   assign instr          = head_s.instr;
   assign instr_pc       = head_s.pc;
   assign stopped        = stopped_q;

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch with an in-order memory model of
// configurable latency; memory word at address A is A+1 unless it is ebreak.
module tb_ifu_prefetch;

   logic        clk, rst_n;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid, instr_ready, stopped;
   logic [31:0] instr, instr_pc;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int lat    = 1;
   logic [31:0] ebreak_addr = 32'h7000_0000;

   typedef struct { logic [31:0] addr; int t; } req_t;
   req_t        pend[$];
   logic [31:0] req_log[$];
   logic [31:0] del_pc[$];
   logic [31:0] del_ins[$];
   int          del_cyc[$];

   ifu_prefetch #(.DEPTH(4), .RESET_PC(32'h8000_0000)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
      .instr_ready(instr_ready), .stopped(stopped)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == ebreak_addr) return 32'h0010_0073;
      return a + 32'd1;
   endfunction

   // Memory model and delivery monitor: drive at negedge, sample 2 units later
   initial begin
      imem_req_ready  = 1'b1;
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
      forever begin
         @(negedge clk);
         if (pend.size() > 0 && pend[0].t + lat <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(pend[0].addr);
            void'(pend.pop_front());
         end else begin
            imem_resp_valid = 1'b0;
         end
         #2;
         if (rst_n && imem_req_valid && imem_req_ready) begin
            pend.push_back('{imem_req_addr, cyc});
            req_log.push_back(imem_req_addr);
         end
         if (rst_n && instr_valid && instr_ready && !redirect_valid) begin
            del_pc.push_back(instr_pc);
            del_ins.push_back(instr);
            del_cyc.push_back(cyc);
         end
      end
   end

   task automatic clear_logs();
      pend.delete(); req_log.delete(); del_pc.delete(); del_ins.delete(); del_cyc.delete();
   endtask

   task automatic apply_reset(input logic ready);
      @(negedge clk);
      rst_n = 1'b0; redirect_valid = 1'b0; instr_ready = ready;
      clear_logs();
      repeat (3) @(negedge clk);
      clear_logs();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0;
      clear_logs();
      repeat (2) @(negedge clk);
      #2;
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b expected 0", imem_req_valid); end
      checks++; if (imem_req_addr !== 32'h8000_0000) begin errors++; $display("FAIL rst_req_addr: got %h expected 80000000", imem_req_addr); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_instr_valid: got %b expected 0", instr_valid); end
      checks++; if (stopped !== 1'b0) begin errors++; $display("FAIL rst_stopped: got %b expected 0", stopped); end
      @(negedge clk);
      clear_logs();
      rst_n = 1'b1;
      #2;
      checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL rel_req_valid: got %b expected 1", imem_req_valid); end
      @(negedge clk); #3;
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL lat_c1_valid: got %b expected 0", instr_valid); end
      @(negedge clk); #3;
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL lat_c2_valid: got %b expected 1", instr_valid); end
      checks++; if (instr_pc !== 32'h8000_0000) begin errors++; $display("FAIL lat_c2_pc: got %h expected 80000000", instr_pc); end
      checks++; if (instr !== 32'h8000_0001) begin errors++; $display("FAIL lat_c2_instr: got %h expected 80000001", instr); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp;
      apply_reset(1'b1);
      repeat (14) @(negedge clk);
      #3;
      checks++;
      if (req_log.size() < 8 || del_pc.size() < 8) begin
         errors++; $display("FAIL b2b_count: got req %0d del %0d expected at least 8 each", req_log.size(), del_pc.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            exp = 32'h8000_0000 + 32'(4 * i);
            checks++; if (req_log[i] !== exp) begin errors++; $display("FAIL b2b_req[%0d]: got %h expected %h", i, req_log[i], exp); end
            checks++; if (del_pc[i] !== exp) begin errors++; $display("FAIL b2b_pc[%0d]: got %h expected %h", i, del_pc[i], exp); end
            checks++; if (del_ins[i] !== exp + 32'd1) begin errors++; $display("FAIL b2b_instr[%0d]: got %h expected %h", i, del_ins[i], exp + 32'd1); end
         end
         for (int i = 0; i < 7; i++) begin
            checks++; if (del_cyc[i+1] !== del_cyc[i] + 1) begin errors++; $display("FAIL b2b_rate[%0d]: got gap %0d expected 1", i, del_cyc[i+1] - del_cyc[i]); end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] exp;
      apply_reset(1'b0);
      repeat (10) @(negedge clk);
      #3;
      checks++; if (req_log.size() !== 4) begin errors++; $display("FAIL bp_req_count: got %0d expected 4", req_log.size()); end
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid: got %b expected 0", imem_req_valid); end
      checks++; if (instr_pc !== 32'h8000_0000) begin errors++; $display("FAIL bp_head_pc: got %h expected 80000000", instr_pc); end
      @(negedge clk);
      instr_ready = 1'b1;
      repeat (8) @(negedge clk);
      #3;
      checks++;
      if (del_pc.size() < 4 || req_log.size() < 5) begin
         errors++; $display("FAIL bp_drain: got del %0d req %0d expected at least 4 and 5", del_pc.size(), req_log.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            exp = 32'h8000_0000 + 32'(4 * i);
            checks++; if (del_pc[i] !== exp) begin errors++; $display("FAIL bp_pc[%0d]: got %h expected %h", i, del_pc[i], exp); end
         end
         checks++; if (req_log[4] !== 32'h8000_0010) begin errors++; $display("FAIL bp_resume_req: got %h expected 80000010", req_log[4]); end
      end
   endtask

   task automatic test_redirect_stale();
      lat = 3;
      apply_reset(1'b1);
      repeat (3) @(negedge clk);
      redirect_valid = 1'b1; redirect_pc = 32'h0000_1000;
      #3;
      checks++; if (req_log.size() !== 3) begin errors++; $display("FAIL stale_outstanding: got %0d expected 3", req_log.size()); end
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL stale_req_in_R: got %b expected 0", imem_req_valid); end
      @(negedge clk);
      redirect_valid = 1'b0;
      #3;
      checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_1000) begin errors++; $display("FAIL stale_req_R1: got %b/%h expected 1/00001000", imem_req_valid, imem_req_addr); end
      for (int k = 0; k < 4; k++) begin
         checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stale_quiet[%0d]: got %b expected 0", k, instr_valid); end
         @(negedge clk); #3;
      end
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0000_1000) begin errors++; $display("FAIL stale_first: got %b/%h expected 1/00001000", instr_valid, instr_pc); end
      repeat (6) @(negedge clk);
      #3;
      checks++;
      if (del_pc.size() < 2) begin
         errors++; $display("FAIL stale_del_count: got %0d expected at least 2", del_pc.size());
      end else begin
         checks++; if (del_pc[0] !== 32'h0000_1000) begin errors++; $display("FAIL stale_pc0: got %h expected 00001000", del_pc[0]); end
         checks++; if (del_pc[1] !== 32'h0000_1004) begin errors++; $display("FAIL stale_pc1: got %h expected 00001004", del_pc[1]); end
         foreach (del_pc[i]) begin
            checks++; if (del_pc[i] < 32'h0000_1000 || del_pc[i] >= 32'h0000_2000) begin errors++; $display("FAIL stale_leak[%0d]: got %h expected 00001000..00001FFC", i, del_pc[i]); end
         end
      end
      lat = 1;
   endtask

   task automatic test_redirect_collide();
      apply_reset(1'b1);
      repeat (4) @(negedge clk);
      redirect_valid = 1'b1; redirect_pc = 32'h0000_2000;
      #1;
      checks++; if (instr_valid !== 1'b1 || imem_resp_valid !== 1'b1) begin errors++; $display("FAIL col_setup: got valid %b resp %b expected 1/1", instr_valid, imem_resp_valid); end
      @(negedge clk);
      redirect_valid = 1'b0;
      #3;
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL col_flush: got %b expected 0", instr_valid); end
      checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_2000) begin errors++; $display("FAIL col_next_req: got %b/%h expected 1/00002000", imem_req_valid, imem_req_addr); end
      repeat (5) @(negedge clk);
      #3;
      checks++;
      if (del_pc.size() < 3) begin
         errors++; $display("FAIL col_del_count: got %0d expected at least 3", del_pc.size());
      end else begin
         checks++; if (del_pc[0] !== 32'h8000_0000) begin errors++; $display("FAIL col_pc0: got %h expected 80000000", del_pc[0]); end
         checks++; if (del_pc[1] !== 32'h8000_0004) begin errors++; $display("FAIL col_pc1: got %h expected 80000004", del_pc[1]); end
         checks++; if (del_pc[2] !== 32'h0000_2000) begin errors++; $display("FAIL col_pc2: got %h expected 00002000", del_pc[2]); end
      end
   endtask

   task automatic test_ebreak();
      ebreak_addr = 32'h8000_0008;
      apply_reset(1'b1);
      repeat (3) @(negedge clk);
      #3;
      checks++; if (stopped !== 1'b0) begin errors++; $display("FAIL eb_early: got %b expected 0", stopped); end
      @(negedge clk); #3;
      checks++; if (stopped !== 1'b1) begin errors++; $display("FAIL eb_rise: got %b expected 1", stopped); end
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL eb_req_block: got %b expected 0", imem_req_valid); end
      repeat (5) @(negedge clk);
      #3;
      checks++; if (stopped !== 1'b1) begin errors++; $display("FAIL eb_hold: got %b expected 1", stopped); end
      checks++; if (req_log.size() !== 4) begin errors++; $display("FAIL eb_req_count: got %0d expected 4", req_log.size()); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL eb_drained: got %b expected 0", instr_valid); end
      checks++;
      if (del_pc.size() !== 3) begin
         errors++; $display("FAIL eb_del_count: got %0d expected 3", del_pc.size());
      end else begin
         checks++; if (del_pc[2] !== 32'h8000_0008 || del_ins[2] !== 32'h0010_0073) begin errors++; $display("FAIL eb_last: got %h/%h expected 80000008/00100073", del_pc[2], del_ins[2]); end
      end
      @(negedge clk);
      redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
      @(negedge clk);
      redirect_valid = 1'b0;
      #3;
      checks++; if (stopped !== 1'b0) begin errors++; $display("FAIL eb_clear: got %b expected 0", stopped); end
      checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0100) begin errors++; $display("FAIL eb_resume_req: got %b/%h expected 1/80000100", imem_req_valid, imem_req_addr); end
      repeat (4) @(negedge clk);
      #3;
      checks++; if (del_pc.size() < 4 || del_pc[del_pc.size() > 3 ? 3 : 0] !== 32'h8000_0100) begin errors++; $display("FAIL eb_resume_pc: got %0d entries, expected entry 3 = 80000100", del_pc.size()); end
      ebreak_addr = 32'h7000_0000;
   endtask

   task automatic test_wrap();
      apply_reset(1'b1);
      @(negedge clk);
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      @(negedge clk);
      redirect_valid = 1'b0;
      #3;
      checks++; if (imem_req_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_first: got %h expected FFFFFFFC", imem_req_addr); end
      @(negedge clk); #3;
      checks++; if (imem_req_addr !== 32'h0000_0000) begin errors++; $display("FAIL wrap_next: got %h expected 00000000", imem_req_addr); end
      repeat (5) @(negedge clk);
      #3;
      checks++;
      if (del_pc.size() < 2) begin
         errors++; $display("FAIL wrap_del_count: got %0d expected at least 2", del_pc.size());
      end else begin
         checks++; if (del_pc[0] !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc0: got %h expected FFFFFFFC", del_pc[0]); end
         checks++; if (del_pc[1] !== 32'h0000_0000 || del_ins[1] !== 32'h0000_0001) begin errors++; $display("FAIL wrap_pc1: got %h/%h expected 00000000/00000001", del_pc[1], del_ins[1]); end
      end
   endtask

   initial begin
      rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
      test_reset();
      test_back_to_back();
      test_backpressure();
      test_redirect_stale();
      test_redirect_collide();
      test_ebreak();
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
